// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write, read, scoreboard issue and flush signals.
// Decode/writeback drive through the master modport; the register file is the slave.
interface regfile_mp_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1
);
    localparam int AW = $clog2(NUM_REGS);

    logic                     ready;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*AW-1:0]     wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     stall;
    logic                     issue_en;
    logic [AW-1:0]            issue_addr;
    logic                     flush;

    modport master (
        input  ready, rd_data, rd_busy, stall,
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, issue_en, issue_addr, flush
    );

    modport slave (
        output ready, rd_data, rd_busy, stall,
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, issue_en, issue_addr, flush
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write-to-read bypass, a pending-write
// scoreboard for RAW hazard detection, and a post-reset clear sequencer that
// zeroes one entry per cycle before the array is declared ready.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter bit ZERO_REG = 1'b1
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state;
    state_t              state_nxt;
    logic                run;
    logic [AW-1:0]       cnt;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;

    // State register: rst restarts the clear sequence from entry 0.
    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= state_nxt;
    end

    // Next state: leave CLEAR once the last entry is being zeroed.
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (cnt == AW'(NUM_REGS - 1)) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = CLEAR;
        endcase
    end

    // FSM outputs: the array is usable only in RUN.
    always_comb begin
        run       = (state == RUN);
        bus.ready = run;
    end

    // Clear counter walks every entry once per clear sequence.
    always_ff @(posedge clk) begin
        if (rst)       cnt <= '0;
        else if (!run) cnt <= cnt + 1'b1;
    end

    // Array update: zero entry cnt while clearing, otherwise apply port writes.
    // NOTE: the array has no reset term on purpose; the clear sequencer zeroes it
    // one entry per cycle, which keeps it mappable to a RAM macro.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run) begin
                regs[cnt] <= '0;
            end else begin
                for (int i = 0; i < NUM_WR; i++) begin
                    if (bus.wr_en[i] && !(ZERO_REG && bus.wr_addr[i*AW +: AW] == '0))
                        // NOTE: non-blocking assignment; when two ports hit the same
                        // address the later loop iteration (higher port) wins.
                        regs[bus.wr_addr[i*AW +: AW]] <= bus.wr_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Scoreboard next value: flush, then write-clear, then issue-set (issue wins).
    always_comb begin
        // NOTE: defaults first so every path assigns the full vector and no latch
        // is inferred.
        pending_nxt = pending;
        if (bus.flush) pending_nxt = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (bus.wr_en[i]) pending_nxt[bus.wr_addr[i*AW +: AW]] = 1'b0;
        end
        if (bus.issue_en && !(ZERO_REG && bus.issue_addr == '0))
            pending_nxt[bus.issue_addr] = 1'b1;
    end

    // Scoreboard register: cleared by rst, frozen while the array is clearing.
    always_ff @(posedge clk) begin
        if (rst)      pending <= '0;
        else if (run) pending <= pending_nxt;
    end

    // Read ports: zero register, bypass from same-cycle writes, hazard flags.
    always_comb begin
        logic [AW-1:0]     a;
        logic              hit;
        logic [DATA_W-1:0] bval;
        bus.rd_data = '0;
        bus.rd_busy = '0;
        a           = '0;
        hit         = 1'b0;
        bval        = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            a    = bus.rd_addr[j*AW +: AW];
            hit  = 1'b0;
            bval = '0;
            for (int i = 0; i < NUM_WR; i++) begin
                if (bus.wr_en[i] && bus.wr_addr[i*AW +: AW] == a) begin
                    hit  = 1'b1;
                    bval = bus.wr_data[i*DATA_W +: DATA_W];
                end
            end
            if (run && bus.rd_en[j] && !(ZERO_REG && a == '0)) begin
                bus.rd_data[j*DATA_W +: DATA_W] = hit ? bval : regs[a];
                bus.rd_busy[j]                  = pending[a] & ~hit;
            end
        end
    end

    assign bus.stall = |bus.rd_busy;
endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model. A second,
// smaller instance covers the 16-entry / 16-bit / 4-read configuration.
module tb_regfile_mp;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int RD = 4;
    localparam int WR = 2;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;
    logic rst_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(RD), .NUM_WR(WR)) bus ();
    regfile_mp_if #(.DATA_W(16), .NUM_REGS(16), .NUM_RD(4),  .NUM_WR(1))  bus_s ();

    regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(RD), .NUM_WR(WR), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    regfile_mp #(.DATA_W(16), .NUM_REGS(16), .NUM_RD(4), .NUM_WR(1), .ZERO_REG(1'b1)) dut_s (
        .clk(clk), .rst(rst_s), .bus(bus_s)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the main instance ----------------
    logic [DW-1:0] m_regs [NR];
    logic [NR-1:0] m_pend;
    int            m_clr   = 0;
    bit            m_valid = 1'b0;

    always @(posedge clk) begin : model
        logic [NR-1:0] p;
        if (rst) begin
            m_valid <= 1'b1;
            m_clr   <= 0;
            m_pend  <= '0;
            for (int r = 0; r < NR; r++) m_regs[r] <= '0;
        end else if (m_valid) begin
            if (m_clr < NR) begin
                m_clr <= m_clr + 1;
            end else begin
                p = m_pend;
                if (bus.flush) p = '0;
                for (int i = 0; i < WR; i++) begin
                    if (bus.wr_en[i]) begin
                        p[bus.wr_addr[i*AW +: AW]] = 1'b0;
                        if (bus.wr_addr[i*AW +: AW] != 0)
                            m_regs[bus.wr_addr[i*AW +: AW]] <= bus.wr_data[i*DW +: DW];
                    end
                end
                if (bus.issue_en && bus.issue_addr != 0) p[bus.issue_addr] = 1'b1;
                m_pend <= p;
            end
        end
    end

    // Compare DUT outputs with the model on every falling edge.
    always @(negedge clk) begin : compare
        logic          ok_ready;
        logic [AW-1:0] a;
        logic [DW-1:0] ed;
        logic          eb;
        logic          hit;
        logic          any_busy;
        if (m_valid) begin
            ok_ready = (m_clr == NR);
            any_busy = 1'b0;
            check("model_ready", bus.ready, ok_ready);
            for (int j = 0; j < RD; j++) begin
                a   = bus.rd_addr[j*AW +: AW];
                ed  = '0;
                eb  = 1'b0;
                hit = 1'b0;
                if (ok_ready && bus.rd_en[j] && a != 0) begin
                    ed = m_regs[a];
                    for (int i = 0; i < WR; i++) begin
                        if (bus.wr_en[i] && bus.wr_addr[i*AW +: AW] == a) begin
                            hit = 1'b1;
                            ed  = bus.wr_data[i*DW +: DW];
                        end
                    end
                    eb = m_pend[a] && !hit;
                end
                any_busy = any_busy | eb;
                check($sformatf("model_rd_data%0d", j), bus.rd_data[j*DW +: DW], ed);
                check($sformatf("model_rd_busy%0d", j), bus.rd_busy[j], eb);
            end
            check("model_stall", bus.stall, any_busy);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en      = '0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.rd_en      = '0;
        bus.rd_addr    = '0;
        bus.issue_en   = 1'b0;
        bus.issue_addr = '0;
        bus.flush      = 1'b0;
    endtask

    task automatic set_wr(input int p, input int addr, input logic [DW-1:0] d);
        bus.wr_en[p]            = 1'b1;
        bus.wr_addr[p*AW +: AW] = AW'(addr);
        bus.wr_data[p*DW +: DW] = d;
    endtask

    task automatic set_rd(input int p, input int addr);
        bus.rd_en[p]            = 1'b1;
        bus.rd_addr[p*AW +: AW] = AW'(addr);
    endtask

    // Count falling edges with ready low, starting just after the rst edge.
    task automatic wait_ready(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.ready === 1'b1 || n >= 200) break;
            n++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        int               n;
        logic [15:0]      s_vals [4];
        rst   = 1'b1;
        rst_s = 1'b1;
        idle();
        bus_s.wr_en = '0; bus_s.wr_addr = '0; bus_s.wr_data = '0;
        bus_s.rd_en = '0; bus_s.rd_addr = '0; bus_s.issue_en = 1'b0;
        bus_s.issue_addr = '0; bus_s.flush = 1'b0;
        step();
        @(negedge clk);
        check("reset_ready", bus.ready, 1'b0);
        check("reset_stall", bus.stall, 1'b0);
        check("reset_rd_busy", bus.rd_busy, 4'h0);
        check("reset_rd_data", bus.rd_data, '0);
        step();
        rst = 1'b0;
        wait_ready(n);
        check("clear_cycles_first", n, 32);

        // Preload every register with DEADBEEF, two per cycle.
        for (int k = 0; k < NR / 2; k++) begin
            idle();
            set_wr(0, 2 * k,     32'hDEAD_BEEF);
            set_wr(1, 2 * k + 1, 32'hDEAD_BEEF);
            step();
        end
        idle();
        rst = 1'b1; step(); rst = 1'b0;
        for (int k = 0; k < 10; k++) step();
        rst = 1'b1; step(); rst = 1'b0;
        wait_ready(n);
        check("clear_cycles_restart", n, 32);
        for (int k = 0; k < NR / RD; k++) begin
            idle();
            for (int j = 0; j < RD; j++) set_rd(j, k * RD + j);
            @(negedge clk);
            for (int j = 0; j < RD; j++)
                check($sformatf("cleared_r%0d", k * RD + j), bus.rd_data[j*DW +: DW], 32'h0);
            step();
        end

        // Write r5 with same-cycle bypass, then from the array.
        idle();
        set_wr(0, 5, 32'h1234_5678);
        set_rd(0, 5);
        @(negedge clk);
        check("bypass_r5", bus.rd_data[31:0], 32'h1234_5678);
        step();
        bus.wr_en = '0;
        @(negedge clk);
        check("array_r5", bus.rd_data[31:0], 32'h1234_5678);
        step();

        // r0 is hardwired.
        idle();
        set_wr(0, 0, 32'hFFFF_FFFF);
        set_rd(0, 0);
        @(negedge clk);
        check("r0_bypass", bus.rd_data[31:0], 32'h0);
        step();
        bus.wr_en = '0;
        @(negedge clk);
        check("r0_array", bus.rd_data[31:0], 32'h0);
        step();

        // Dual write to r7: higher port wins.
        idle();
        set_wr(0, 7, 32'h1);
        set_wr(1, 7, 32'h2);
        set_rd(1, 7);
        @(negedge clk);
        check("dual_bypass_r7", bus.rd_data[63:32], 32'h2);
        step();
        bus.wr_en = '0;
        @(negedge clk);
        check("dual_array_r7", bus.rd_data[63:32], 32'h2);
        step();

        // Scoreboard hazard on r9.
        idle();
        bus.issue_en = 1'b1; bus.issue_addr = 5'd9;
        set_rd(0, 9);
        @(negedge clk);
        check("issue_cycle_busy", bus.rd_busy[0], 1'b0);
        step();
        bus.issue_en = 1'b0;
        @(negedge clk);
        check("hazard_busy", bus.rd_busy[0], 1'b1);
        check("hazard_stall", bus.stall, 1'b1);
        step();
        set_wr(1, 9, 32'hAA);
        @(negedge clk);
        check("wb_busy", bus.rd_busy[0], 1'b0);
        check("wb_stall", bus.stall, 1'b0);
        check("wb_data", bus.rd_data[31:0], 32'hAA);
        step();
        bus.wr_en = '0;
        @(negedge clk);
        check("after_wb_busy", bus.rd_busy[0], 1'b0);
        check("after_wb_data", bus.rd_data[31:0], 32'hAA);
        step();

        // Issue / write / flush collision on r3 with r4 pending beforehand.
        idle();
        bus.issue_en = 1'b1; bus.issue_addr = 5'd4;
        step();
        idle();
        bus.issue_en = 1'b1; bus.issue_addr = 5'd3;
        set_wr(0, 3, 32'h33);
        bus.flush = 1'b1;
        step();
        idle();
        set_rd(0, 3);
        set_rd(1, 4);
        @(negedge clk);
        check("collision_r3_busy", bus.rd_busy[0], 1'b1);
        check("collision_r4_busy", bus.rd_busy[1], 1'b0);
        check("collision_r3_data", bus.rd_data[31:0], 32'h33);
        step();
        idle();
        bus.issue_en = 1'b1; bus.issue_addr = 5'd0;
        set_wr(0, 3, 32'h34);
        step();
        idle();
        set_rd(2, 0);
        @(negedge clk);
        check("r0_never_busy", bus.rd_busy[2], 1'b0);
        step();

        // Randomized traffic, checked by the compare process.
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < WR; i++) begin
                if ($urandom_range(0, 2) == 0)
                    set_wr(i, ($urandom_range(0, 3) == 0) ? $urandom_range(0, NR - 1)
                                                          : $urandom_range(0, 7), $urandom);
            end
            for (int j = 0; j < RD; j++) begin
                if ($urandom_range(0, 3) != 0) set_rd(j, $urandom_range(0, 7));
            end
            bus.issue_en   = ($urandom_range(0, 2) == 0);
            bus.issue_addr = AW'($urandom_range(0, 7));
            bus.flush      = ($urandom_range(0, 19) == 0);
            step();
        end
        rst = 1'b0;
        idle();
        step();

        // Small configuration: 16 entries, 16-bit data, 4 read ports.
        step();
        rst_s = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus_s.ready === 1'b1 || n >= 200) break;
            n++;
            @(posedge clk);
            #1;
        end
        check("small_clear_cycles", n, 16);
        step();
        s_vals[0] = 16'hA1B2;
        s_vals[1] = 16'h0C3D;
        s_vals[2] = 16'hFFFF;
        s_vals[3] = 16'h8001;
        for (int k = 0; k < 4; k++) begin
            bus_s.wr_en   = 1'b1;
            bus_s.wr_addr = 4'(k + 1);
            bus_s.wr_data = s_vals[k];
            step();
        end
        bus_s.wr_en   = 1'b0;
        bus_s.rd_en   = 4'hF;
        bus_s.rd_addr = {4'd4, 4'd3, 4'd2, 4'd1};
        @(negedge clk);
        for (int j = 0; j < 4; j++)
            check($sformatf("small_rd%0d", j), bus_s.rd_data[j*16 +: 16], s_vals[j]);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the MIPS pipeline, replacing the fixed 2-read/1-write file. It sits between decode (read and issue side) and writeback (write side). It adds a configurable number of read and write ports, same-cycle write-to-read bypass, and a per-register pending scoreboard that reports read-after-write hazards to decode. A post-reset clear sequencer zeroes the array one entry per cycle.

## Interface
- DATA_W, 32, register data width
- NUM_REGS, 32, number of architectural registers, power of two, ≥2
- NUM_RD, 2, read ports, 1..4
- NUM_WR, 1, write ports, 1..2
- ZERO_REG, 1, 1 = register 0 is hardwired to zero
- AW (localparam) = $clog2(NUM_REGS)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- ready  out  1  1 = clear sequence done and array usable
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*AW  write addresses; port i occupies bits [i*AW +: AW]
- wr_data  in  NUM_WR*DATA_W  write data, packed the same way
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*AW  read addresses, packed
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- rd_busy  out  NUM_RD  per-port hazard flag, combinational
- stall  out  1  OR of rd_busy
- issue_en  in  1  marks issue_addr as pending a write
- issue_addr  in  AW  destination register of the issuing instruction
- flush  in  1  clears all pending bits

## Operation
- State machine with two states: CLEAR and RUN.
  - rst=1: next state CLEAR, clear counter = 0, all pending bits = 0.
  - CLEAR: each cycle regs[cnt] <= 0 and cnt++. When cnt == NUM_REGS-1, that entry is written and the state goes to RUN.
  - RUN: stays in RUN until rst.
- ready = (state == RUN). In CLEAR, all wr_en, issue_en and flush inputs are ignored; rd_data = 0 and rd_busy = 0.
- Writes in RUN: regs[wr_addr[i]] <= wr_data[i] when wr_en[i].
  - ZERO_REG=1: writes to address 0 are dropped.
  - If two ports write the same address in one cycle, the higher port index wins.
- Reads (combinational). Priority:
  1. not ready or rd_en=0 → 0
  2. addr 0 with ZERO_REG=1 → 0
  3. same-cycle write to the address → bypass that write's data (highest port index)
  4. otherwise regs[addr]
- Scoreboard: one pending bit per register, updated at the clock edge. Precedence, lowest first:
  1. flush clears all bits.
  2. Each wr_en clears pending[wr_addr].
  3. issue_en sets pending[issue_addr], so issue beats write and flush for the same register.
  - Issue to addr 0 with ZERO_REG=1 is ignored.
- rd_busy[j] = ready & rd_en[j] & pending[rd_addr[j]] & ~(same-cycle write to rd_addr[j]) & ~(ZERO_REG & rd_addr[j]==0).

## Timing
- Reset values: ready=0, stall=0, rd_busy=0, rd_data=0, all pending bits=0. Array contents become 0 via the clear sequence.
- Clear latency: rst sampled high at edge E0 → ready=1 after edge E0+NUM_REGS (NUM_REGS CLEAR cycles).
- rst asserted mid-CLEAR or mid-RUN restarts the clear from entry 0. Writes presented in the same cycle as rst are lost.
- Write latency: data is stored at the edge. It is visible combinationally in the same cycle through bypass and from the array in the next cycle.
- Issue latency: pending is set at the edge, so rd_busy can first rise in the next cycle.
- Writeback in the same cycle as a hazardous read deasserts rd_busy in that cycle (no stall bubble).
- No handshakes. All inputs are sampled every cycle; decode must hold its request while stall=1.

## Test plan
- Reset/clear: preload regs with 0xDEADBEEF, pulse rst 1 cycle. Required: ready low for exactly 32 cycles; then all 32 reads = 0. Re-pulse rst at clear cycle 10 → ready low 32 more cycles.
- Write/read/bypass: write r5=0x12345678. Required: same-cycle read of r5 returns 0x12345678 (bypass); next-cycle read from the array returns the same. Write r0=0xFFFFFFFF → read r0 = 0.
- Dual-write conflict (NUM_WR=2): port0 r7=0x1, port1 r7=0x2 in one cycle. Required: r7 reads 0x2 and the bypass value is 0x2.
- Scoreboard hazard: issue r9. Required: next cycle read r9 gives rd_busy=1 and stall=1; a write of r9=0xAA in a later cycle gives rd_busy=0 and rd_data=0xAA that cycle; the following cycle pending is clear.
- Issue/write/flush collision: in one cycle issue r3 while writing r3 and asserting flush. Required: pending[r3]=1, all other pending bits 0. Issue r0 → never busy.
- Port scaling (NUM_RD=4, NUM_REGS=16, DATA_W=16): 4 simultaneous reads of distinct registers return the correct 16-bit values; ready rises after 16 clear cycles.
